uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
Multicycle control sequencer for the RV32I-subset core. It steps the shared datapath (PC, IR, register file, immediate unit, ALU, data memory) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one instruction at a time. It replaces combinational single-cycle control where the datapath is time-shared and data memory has a ready handshake. It also counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter INSTRET (wraps modulo 2^CNT_W).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
RUN  in  1  level; FETCH advances only while 1.
OP_CODE  in  7  IR[6:0].
FUNCT_3  in  3  IR[14:12].
FUNCT_7  in  7  IR[31:25].
BR_TAKEN  in  1  datapath comparator result for the current branch condition.
MEM_READY  in  1  data memory completes the access this cycle.
IR_WE  out  1  load instruction register.
PC_WE  out  1  load PC.
CRF  out  1  register-file write enable.
CEU  out  3  immediate type: I=000, S=001, B=010, U=011, J=100.
CALU  out  3  ADD=000, SUB=001, AND=010, OR=011, XOR=100, SLL=101, SRA=110.
ALUS1  out  1  ALU A: 0=rs1, 1=PC.
ALUS2  out  1  ALU B: 0=rs2, 1=immediate.
BS  out  1  comparator mode: 0=NE, 1=GE (signed).
PCS  out  2  PC source: 00=PC+4, 01=PC+imm, 10=ALU result with LSB cleared.
DWS  out  2  write-back source: 00=ALU, 01=memory data, 10=PC+4, 11=immediate.
MEM_RD  out  1  data memory read request.
CDM  out  1  data memory write request.
ILLEGAL  out  1  sticky; set when an unsupported encoding is decoded.
STATE  out  3  current state, debug.
INSTRET  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH=000, DECODE=001, EXECUTE=010, MEMORY=011, WRITEBACK=100, TRAP=101.
- Reset (asynchronous, immediate): STATE=FETCH, INSTRET=0, ILLEGAL=0, decode registers cleared. All enables and requests (IR_WE, PC_WE, CRF, MEM_RD, CDM) =0. All selects =0.
- Reset mid-operation aborts the instruction. A pending MEM_RD/CDM drops the same instant and no PC or register-file write occurs.
- FETCH: IR_WE=RUN. If RUN=1, go to DECODE; otherwise hold.
- DECODE: OP_CODE/FUNCT_3/FUNCT_7 are registered into a class code and CEU/CALU/BS/PCS/DWS fields.
  - Supported: ADDI, ANDI, ORI, XORI, SLLI, SRAI, LW, JALR, SW, ADD, SUB, SLL, LUI, BNE, BGE, JAL.
  - Anything else goes to TRAP.
- No combinational path from OP_CODE/FUNCT_* to any output. Outputs are functions of STATE and the decode registers, plus MEM_READY and BR_TAKEN where stated below.
- EXECUTE:
  - ALU/LUI/JAL/JALR: go to WRITEBACK.
  - LW/SW: ALUS2=1, CALU=ADD; go to MEMORY.
  - Branch: CALU=SUB, BS per funct3. PC_WE=1 with PCS=01 if BR_TAKEN, else 00. INSTRET+1, go to FETCH.
- MEMORY:
  - MEM_RD (LW) or CDM (SW) is held high until MEM_READY=1. Address operands are held stable throughout.
  - SW with MEM_READY: PC_WE=1, PCS=00, INSTRET+1, go to FETCH.
  - LW with MEM_READY: go to WRITEBACK.
- WRITEBACK: CRF=1, DWS per class. PC_WE=1 with PCS=01 (JAL), 10 (JALR) or 00 (others). INSTRET+1, go to FETCH.
- TRAP: ILLEGAL=1. All enables are 0. The state persists until RST.
- Latency in cycles, from FETCH entry to next FETCH: branch 3; ALU/LUI/JAL/JALR 4; SW 4+waits; LW 5+waits. Waits = cycles spent with MEM_READY=0.
- MEM_READY outside MEMORY and BR_TAKEN outside a branch EXECUTE are ignored.
- INSTRET wraps from all-ones to 0.

Decomposition:
- Package uc_pkg holds:
  - state encodings;
  - opcode constants (0010011, 0110011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111);
  - CEU/CALU/PCS/DWS encodings;
  - instruction-class enum.
- One combinational sub-module, decodificador_instr, maps OP_CODE/FUNCT_3/FUNCT_7 to class, CEU, CALU, BS, PCS, DWS and illegal. uc_multiciclo registers its outputs in DECODE.

Test Plan:
- RST=1 pulse mid-MEMORY of SW with CDM=1 -> CDM drops asynchronously; STATE=000, INSTRET=0, no PC_WE.
- ADD (0110011/000/0000000) with RUN=1 -> STATE sequence 000,001,010,100. In WRITEBACK: CRF=1, DWS=00, CALU=000, PC_WE=1, PCS=00. INSTRET=1.
- LW (0000011/010) with MEM_READY low for 3 cycles -> MEM_RD high exactly 4 cycles, then WRITEBACK with DWS=01. Total 8 cycles.
- BGE (1100011/101): BR_TAKEN=1 -> BS=1, PCS=01, PC_WE in EXECUTE, 3 cycles. Repeat with BR_TAKEN=0 -> PCS=00, CRF never asserted.
- JALR (1100111/000) -> WRITEBACK with DWS=10, PCS=10, ALUS2=1, CEU=000. JAL (1101111) -> PCS=01, CEU=100.
- Opcode 0000000 -> TRAP, ILLEGAL=1, no enables for 20 cycles. RST clears it. RUN=0 in FETCH holds STATE=000 with IR_WE=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared definitions for the multicycle control sequencer: state
// encodings, RV32I opcodes, datapath select encodings and the
// instruction-class enum latched at decode.
package uc_pkg;

  typedef enum logic [2:0] {
    S_FETCH     = 3'b000,
    S_DECODE    = 3'b001,
    S_EXECUTE   = 3'b010,
    S_MEMORY    = 3'b011,
    S_WRITEBACK = 3'b100,
    S_TRAP      = 3'b101
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] CEU_I = 3'b000;
  localparam logic [2:0] CEU_S = 3'b001;
  localparam logic [2:0] CEU_B = 3'b010;
  localparam logic [2:0] CEU_U = 3'b011;
  localparam logic [2:0] CEU_J = 3'b100;

  localparam logic [2:0] CALU_ADD = 3'b000;
  localparam logic [2:0] CALU_SUB = 3'b001;
  localparam logic [2:0] CALU_AND = 3'b010;
  localparam logic [2:0] CALU_OR  = 3'b011;
  localparam logic [2:0] CALU_XOR = 3'b100;
  localparam logic [2:0] CALU_SLL = 3'b101;
  localparam logic [2:0] CALU_SRA = 3'b110;

  localparam logic [1:0] PCS_PC4 = 2'b00;
  localparam logic [1:0] PCS_IMM = 2'b01;
  localparam logic [1:0] PCS_ALU = 2'b10;

  localparam logic [1:0] DWS_ALU = 2'b00;
  localparam logic [1:0] DWS_MEM = 2'b01;
  localparam logic [1:0] DWS_PC4 = 2'b10;
  localparam logic [1:0] DWS_IMM = 2'b11;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI
  } iclass_t;

endpackage

// File: rtl/decodificador_instr.sv
// Combinational instruction decoder.
// Inputs : op_code_i, funct_3_i, funct_7_i (instruction fields)
// Outputs: class_o, ceu_o, calu_o, bs_o, pcs_o, dws_o, alus1_o, alus2_o,
//          illegal_o (encoding outside the supported subset)
module decodificador_instr
  import uc_pkg::*;
(
  input  logic [6:0] op_code_i,
  input  logic [2:0] funct_3_i,
  input  logic [6:0] funct_7_i,
  output iclass_t    class_o,
  output logic [2:0] ceu_o,
  output logic [2:0] calu_o,
  output logic       bs_o,
  output logic [1:0] pcs_o,
  output logic [1:0] dws_o,
  output logic       alus1_o,
  output logic       alus2_o,
  output logic       illegal_o
);

  always_comb begin
    class_o   = CL_ALU;
    ceu_o     = CEU_I;
    calu_o    = CALU_ADD;
    bs_o      = 1'b0;
    pcs_o     = PCS_PC4;
    dws_o     = DWS_ALU;
    alus1_o   = 1'b0;
    alus2_o   = 1'b1;
    illegal_o = 1'b0;
    unique case (op_code_i)
      OP_IMM: begin
        unique case (funct_3_i)
          3'b000: calu_o = CALU_ADD;
          3'b111: calu_o = CALU_AND;
          3'b110: calu_o = CALU_OR;
          3'b100: calu_o = CALU_XOR;
          3'b001: begin
            calu_o    = CALU_SLL;
            illegal_o = (funct_7_i != 7'b0000000);
          end
          3'b101: begin
            calu_o    = CALU_SRA;
            illegal_o = (funct_7_i != 7'b0100000);
          end
          default: illegal_o = 1'b1;
        endcase
      end
      OP_REG: begin
        alus2_o = 1'b0;
        if (funct_3_i == 3'b000 && funct_7_i == 7'b0000000)      calu_o = CALU_ADD;
        else if (funct_3_i == 3'b000 && funct_7_i == 7'b0100000) calu_o = CALU_SUB;
        else if (funct_3_i == 3'b001 && funct_7_i == 7'b0000000) calu_o = CALU_SLL;
        else                                                     illegal_o = 1'b1;
      end
      OP_LOAD: begin
        class_o   = CL_LOAD;
        dws_o     = DWS_MEM;
        illegal_o = (funct_3_i != 3'b010);
      end
      OP_STORE: begin
        class_o   = CL_STORE;
        ceu_o     = CEU_S;
        illegal_o = (funct_3_i != 3'b010);
      end
      OP_BRANCH: begin
        class_o = CL_BRANCH;
        ceu_o   = CEU_B;
        calu_o  = CALU_SUB;
        pcs_o   = PCS_IMM;
        alus2_o = 1'b0;
        unique case (funct_3_i)
          3'b001:  bs_o = 1'b0;
          3'b101:  bs_o = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_JAL: begin
        class_o = CL_JAL;
        ceu_o   = CEU_J;
        pcs_o   = PCS_IMM;
        dws_o   = DWS_PC4;
        alus1_o = 1'b1;
      end
      OP_JALR: begin
        class_o   = CL_JALR;
        pcs_o     = PCS_ALU;
        dws_o     = DWS_PC4;
        illegal_o = (funct_3_i != 3'b000);
      end
      OP_LUI: begin
        class_o = CL_LUI;
        ceu_o   = CEU_U;
        dws_o   = DWS_IMM;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control sequencer for the RV32I-subset core.
// Inputs : CLK, RST (async, active high), RUN, OP_CODE/FUNCT_3/FUNCT_7,
//          BR_TAKEN, MEM_READY
// Outputs: IR_WE, PC_WE, CRF, MEM_RD, CDM enables; CEU, CALU, ALUS1, ALUS2,
//          BS, PCS, DWS selects; ILLEGAL (sticky), STATE, INSTRET
module uc_multiciclo
  import uc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic [6:0]       OP_CODE,
  input  logic [2:0]       FUNCT_3,
  input  logic [6:0]       FUNCT_7,
  input  logic             BR_TAKEN,
  input  logic             MEM_READY,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic             CRF,
  output logic [2:0]       CEU,
  output logic [2:0]       CALU,
  output logic             ALUS1,
  output logic             ALUS2,
  output logic             BS,
  output logic [1:0]       PCS,
  output logic [1:0]       DWS,
  output logic             MEM_RD,
  output logic             CDM,
  output logic             ILLEGAL,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] INSTRET
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;

  iclass_t    class_q;
  logic [2:0] ceu_q, calu_q;
  logic       bs_q, alus1_q, alus2_q;
  logic [1:0] pcs_q, dws_q;

  iclass_t    dec_class;
  logic [2:0] dec_ceu, dec_calu;
  logic       dec_bs, dec_alus1, dec_alus2, dec_illegal;
  logic [1:0] dec_pcs, dec_dws;

  decodificador_instr u_dec (
    .op_code_i (OP_CODE),
    .funct_3_i (FUNCT_3),
    .funct_7_i (FUNCT_7),
    .class_o   (dec_class),
    .ceu_o     (dec_ceu),
    .calu_o    (dec_calu),
    .bs_o      (dec_bs),
    .pcs_o     (dec_pcs),
    .dws_o     (dec_dws),
    .alus1_o   (dec_alus1),
    .alus2_o   (dec_alus2),
    .illegal_o (dec_illegal)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
      class_q   <= CL_ALU;
      ceu_q     <= '0;
      calu_q    <= '0;
      bs_q      <= 1'b0;
      alus1_q   <= 1'b0;
      alus2_q   <= 1'b0;
      pcs_q     <= '0;
      dws_q     <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      // Instruction fields are captured only here, so outputs never see
      // OP_CODE/FUNCT_* combinationally.
      if (state_q == S_DECODE) begin
        class_q <= dec_class;
        ceu_q   <= dec_ceu;
        calu_q  <= dec_calu;
        bs_q    <= dec_bs;
        alus1_q <= dec_alus1;
        alus2_q <= dec_alus2;
        pcs_q   <= dec_pcs;
        dws_q   <= dec_dws;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    IR_WE     = 1'b0;
    PC_WE     = 1'b0;
    CRF       = 1'b0;
    MEM_RD    = 1'b0;
    CDM       = 1'b0;
    CEU       = '0;
    CALU      = '0;
    ALUS1     = 1'b0;
    ALUS2     = 1'b0;
    BS        = 1'b0;
    PCS       = '0;
    DWS       = '0;
    if (state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK) begin
      CEU   = ceu_q;
      CALU  = calu_q;
      ALUS1 = alus1_q;
      ALUS2 = alus2_q;
      BS    = bs_q;
      PCS   = pcs_q;
      DWS   = dws_q;
    end
    unique case (state_q)
      S_FETCH: begin
        IR_WE = RUN;
        if (RUN) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (class_q == CL_BRANCH) begin
          PC_WE     = 1'b1;
          PCS       = BR_TAKEN ? pcs_q : PCS_PC4;
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (class_q == CL_LOAD || class_q == CL_STORE) begin
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        MEM_RD = (class_q == CL_LOAD);
        CDM    = (class_q == CL_STORE);
        if (MEM_READY) begin
          if (class_q == CL_STORE) begin
            PC_WE     = 1'b1;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        CRF       = 1'b1;
        PC_WE     = 1'b1;
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign STATE   = state_q;
  assign INSTRET = instret_q;
  assign ILLEGAL = illegal_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

  localparam int TB_CNT_W = 4;

  logic CLK = 1'b0;
  logic RST, RUN, BR_TAKEN, MEM_READY;
  logic [6:0] OP_CODE, FUNCT_7;
  logic [2:0] FUNCT_3;
  logic IR_WE, PC_WE, CRF, ALUS1, ALUS2, BS, MEM_RD, CDM, ILLEGAL;
  logic [2:0] CEU, CALU, STATE;
  logic [1:0] PCS, DWS;
  logic [TB_CNT_W-1:0] INSTRET;

  always #5 CLK = ~CLK;

  uc_multiciclo #(.CNT_W(TB_CNT_W)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3),
    .FUNCT_7(FUNCT_7), .BR_TAKEN(BR_TAKEN), .MEM_READY(MEM_READY),
    .IR_WE(IR_WE), .PC_WE(PC_WE), .CRF(CRF), .CEU(CEU), .CALU(CALU),
    .ALUS1(ALUS1), .ALUS2(ALUS2), .BS(BS), .PCS(PCS), .DWS(DWS),
    .MEM_RD(MEM_RD), .CDM(CDM), .ILLEGAL(ILLEGAL), .STATE(STATE),
    .INSTRET(INSTRET)
  );

  int errors = 0;
  int checks = 0;
  logic [TB_CNT_W-1:0] exp_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // chk bits: [0] ceu, [1] calu, [2] alus2, [3] dws, [4] bs
  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic br; logic idle_rdy; int waits;
    int lat; int mrd; int mwr; int crf;
    logic [1:0] pcs; logic [1:0] dws; logic [2:0] calu; logic [2:0] ceu;
    logic alus2; logic bs; logic [4:0] chk;
  } vec_t;

  vec_t vecs[20];

  task automatic run_row(input vec_t v, input int idx);
    int lat, n_mrd, n_mwr, n_crf, n_pcwe, n_irwe, wc;
    logic [1:0] r_pcs, r_dws; logic [2:0] r_calu, r_ceu; logic r_alus2, r_bs;
    bit done;
    string p;
    p = $sformatf("row%0d", idx);
    r_pcs = 'x; r_dws = 'x; r_calu = 'x; r_ceu = 'x; r_alus2 = 1'bx; r_bs = 1'bx;
    OP_CODE = v.op; FUNCT_3 = v.f3; FUNCT_7 = v.f7;
    RUN = 1'b1; BR_TAKEN = v.br; MEM_READY = v.idle_rdy;
    lat = 0; n_mrd = 0; n_mwr = 0; n_crf = 0; n_pcwe = 0; n_irwe = 0; wc = 0;
    done = 0;
    while (!done) begin
      if (lat > 0) begin
        @(negedge CLK);
        if (STATE == 3'b000 || lat >= 64) done = 1;
      end
      if (!done) begin
        lat++;
        if (STATE == 3'b011) begin
          MEM_READY = (wc == v.waits);
          wc++;
        end else begin
          MEM_READY = v.idle_rdy;
        end
        #1;
        n_mrd += int'(MEM_RD); n_mwr += int'(CDM); n_crf += int'(CRF);
        n_irwe += int'(IR_WE);
        if (PC_WE) begin
          n_pcwe++;
          r_pcs = PCS; r_dws = DWS; r_calu = CALU; r_ceu = CEU;
          r_alus2 = ALUS2; r_bs = BS;
        end
      end
    end
    exp_ir = exp_ir + 1'b1;
    chk({p, " latency"}, lat, v.lat);
    chk({p, " mem_rd cycles"}, n_mrd, v.mrd);
    chk({p, " cdm cycles"}, n_mwr, v.mwr);
    chk({p, " crf cycles"}, n_crf, v.crf);
    chk({p, " ir_we cycles"}, n_irwe, 1);
    chk({p, " pc_we cycles"}, n_pcwe, 1);
    chk({p, " pcs"}, r_pcs, v.pcs);
    chk({p, " instret"}, INSTRET, exp_ir);
    if (v.chk[0]) chk({p, " ceu"}, r_ceu, v.ceu);
    if (v.chk[1]) chk({p, " calu"}, r_calu, v.calu);
    if (v.chk[2]) chk({p, " alus2"}, r_alus2, v.alus2);
    if (v.chk[3]) chk({p, " dws"}, r_dws, v.dws);
    if (v.chk[4]) chk({p, " bs"}, r_bs, v.bs);
  endtask

  task automatic trap_test(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input string name);
    int bad_en, bad_st;
    OP_CODE = op; FUNCT_3 = f3; FUNCT_7 = f7; RUN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk({name, " trap state"}, STATE, 3'b101);
    bad_en = 0; bad_st = 0;
    RUN = 1'b1; MEM_READY = 1'b1; BR_TAKEN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #1;
      if (IR_WE | PC_WE | CRF | MEM_RD | CDM) bad_en++;
      if (STATE !== 3'b101 || ILLEGAL !== 1'b1) bad_st++;
    end
    chk({name, " enables in trap"}, bad_en, 0);
    chk({name, " trap hold/illegal"}, bad_st, 0);
    #2 RST = 1'b1;
    #1;
    chk({name, " illegal after rst"}, ILLEGAL, 1'b0);
    chk({name, " state after rst"}, STATE, 3'b000);
    @(negedge CLK);
    RST = 1'b0; MEM_READY = 1'b0; BR_TAKEN = 1'b0;
    exp_ir = '0;
  endtask

  initial begin
    //             op          f3      f7        br idl w  lat mrd mwr crf pcs    dws    calu    ceu     a2   bs   chk
    vecs[0]  = '{7'b0110011, 3'b000, 7'h00,    1, 1, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0, 5'b01110};
    vecs[1]  = '{7'b0110011, 3'b000, 7'h20,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b001, 3'b000, 0, 0, 5'b01110};
    vecs[2]  = '{7'b0110011, 3'b001, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b101, 3'b000, 0, 0, 5'b01110};
    vecs[3]  = '{7'b0010011, 3'b000, 7'h7f,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0, 5'b01111};
    vecs[4]  = '{7'b0010011, 3'b111, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b010, 3'b000, 1, 0, 5'b01111};
    vecs[5]  = '{7'b0010011, 3'b110, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b011, 3'b000, 1, 0, 5'b01111};
    vecs[6]  = '{7'b0010011, 3'b100, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b100, 3'b000, 1, 0, 5'b01111};
    vecs[7]  = '{7'b0010011, 3'b001, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b101, 3'b000, 1, 0, 5'b01111};
    vecs[8]  = '{7'b0010011, 3'b101, 7'h20,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b00, 3'b110, 3'b000, 1, 0, 5'b01111};
    vecs[9]  = '{7'b0000011, 3'b010, 7'h00,    0, 0, 3, 8, 4, 0, 1, 2'b00, 2'b01, 3'b000, 3'b000, 1, 0, 5'b01111};
    vecs[10] = '{7'b0000011, 3'b010, 7'h00,    1, 1, 0, 5, 1, 0, 1, 2'b00, 2'b01, 3'b000, 3'b000, 1, 0, 5'b01111};
    vecs[11] = '{7'b0100011, 3'b010, 7'h00,    0, 0, 2, 6, 0, 3, 0, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0, 5'b00111};
    vecs[12] = '{7'b0100011, 3'b010, 7'h00,    1, 1, 0, 4, 0, 1, 0, 2'b00, 2'b00, 3'b000, 3'b001, 1, 0, 5'b00111};
    vecs[13] = '{7'b1100011, 3'b101, 7'h00,    1, 1, 0, 3, 0, 0, 0, 2'b01, 2'b00, 3'b001, 3'b010, 0, 1, 5'b10111};
    vecs[14] = '{7'b1100011, 3'b101, 7'h00,    0, 0, 0, 3, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b010, 0, 1, 5'b10111};
    vecs[15] = '{7'b1100011, 3'b001, 7'h00,    1, 0, 0, 3, 0, 0, 0, 2'b01, 2'b00, 3'b001, 3'b010, 0, 0, 5'b10111};
    vecs[16] = '{7'b1100011, 3'b001, 7'h00,    0, 1, 0, 3, 0, 0, 0, 2'b00, 2'b00, 3'b001, 3'b010, 0, 0, 5'b10111};
    vecs[17] = '{7'b1100111, 3'b000, 7'h00,    0, 0, 0, 4, 0, 0, 1, 2'b10, 2'b10, 3'b000, 3'b000, 1, 0, 5'b01101};
    vecs[18] = '{7'b1101111, 3'b011, 7'h15,    1, 1, 0, 4, 0, 0, 1, 2'b01, 2'b10, 3'b000, 3'b100, 0, 0, 5'b01001};
    vecs[19] = '{7'b0110111, 3'b110, 7'h2a,    0, 0, 0, 4, 0, 0, 1, 2'b00, 2'b11, 3'b000, 3'b011, 0, 0, 5'b01001};

    RST = 1'b1; RUN = 1'b0; BR_TAKEN = 1'b0; MEM_READY = 1'b0;
    OP_CODE = '0; FUNCT_3 = '0; FUNCT_7 = '0;
    exp_ir = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset state", STATE, 3'b000);
    chk("reset instret", INSTRET, 0);
    chk("reset illegal", ILLEGAL, 1'b0);
    chk("reset enables", {IR_WE, PC_WE, CRF, MEM_RD, CDM}, 5'b0);
    chk("reset selects", {CEU, CALU, ALUS1, ALUS2, BS, PCS, DWS}, 15'b0);
    @(negedge CLK);
    RST = 1'b0;

    // RUN=0 holds FETCH
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      chk($sformatf("hold state %0d", i), STATE, 3'b000);
      chk($sformatf("hold ir_we %0d", i), IR_WE, 1'b0);
    end

    // ADD: explicit state walk
    @(negedge CLK);
    OP_CODE = 7'b0110011; FUNCT_3 = 3'b000; FUNCT_7 = 7'h00; RUN = 1'b1;
    #1 chk("add fetch ir_we", IR_WE, 1'b1);
    @(negedge CLK); #1 chk("add st decode", STATE, 3'b001);
    @(negedge CLK); #1 chk("add st execute", STATE, 3'b010);
    @(negedge CLK); #1 chk("add st writeback", STATE, 3'b100);
    chk("add wb crf/pc_we", {CRF, PC_WE}, 2'b11);
    chk("add wb dws/pcs/calu", {DWS, PCS, CALU}, 7'b0);
    @(negedge CLK); #1 chk("add back to fetch", STATE, 3'b000);
    chk("add instret", INSTRET, 1);
    exp_ir = 1;

    // table; counter is 4 bits wide so it wraps partway through
    for (int i = 0; i < 20; i++) run_row(vecs[i], i);

    // reset during SW memory access
    OP_CODE = 7'b0100011; FUNCT_3 = 3'b010; FUNCT_7 = 7'h00; RUN = 1'b1;
    MEM_READY = 1'b0;
    repeat (3) @(negedge CLK);
    #1 chk("sw mid state", STATE, 3'b011);
    chk("sw mid cdm", CDM, 1'b1);
    #2 RST = 1'b1;
    #1;
    chk("rst cdm drops", CDM, 1'b0);
    chk("rst state", STATE, 3'b000);
    chk("rst instret", INSTRET, 0);
    chk("rst pc_we/crf", {PC_WE, CRF}, 2'b00);
    @(negedge CLK);
    RST = 1'b0; RUN = 1'b0;
    #1 chk("post rst instret", INSTRET, 0);
    exp_ir = '0;

    trap_test(7'b0000000, 3'b000, 7'h00, "op0");
    trap_test(7'b0010011, 3'b010, 7'h00, "slti");
    trap_test(7'b0110011, 3'b000, 7'h01, "badf7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
